// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array datapath: default sizes,
// feeder FSM states and feed-sequence length.
package tpu_pkg;

    localparam int DEF_BITS_AB = 8;
    localparam int DEF_DIM     = 8;

    typedef enum logic {
        IDLE,
        FEED
    } feeder_state_t;

    // Feed length: 2*DIM-1 skewed operand cycles plus DIM-1 flush cycles.
    function automatic int FEED_CYCLES(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/systolic_feeder.sv
// Buffers a DIM x DIM operand matrix and streams it diagonally skewed into the
// west edge of the MAC array. Optional SYSTOLIC_FEEDER_TRANSPOSE_EN adds column-major feed.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int DIM     = DEF_DIM
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   WrEn,
    input  logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] wr_row,
    input  logic [DIM*BITS_AB-1:0]                 wr_data,
    input  logic                                   start,
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
    input  logic                                   transpose,
`endif
    output logic                                   busy,
    output logic                                   done,
    output logic                                   en_out,
    output logic [DIM*BITS_AB-1:0]                 Aout
);

    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int NCYC = FEED_CYCLES(DIM);
    localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    feeder_state_t          state;
    logic [CW-1:0]          cnt;
    logic [DIM*BITS_AB-1:0] mem [DIM];
    logic [DIM*BITS_AB-1:0] lanes;
    logic                   tr_q;
    int                     k;

    // Skew by index compare: lane i reads element t-i straight from the buffer.
    always_comb begin
        lanes = '0;
        k     = 0;
        for (int unsigned i = 0; i < DIM; i++) begin
            if ((int'(cnt) >= int'(i)) && ((int'(cnt) - int'(i)) < DIM)) begin
                k = int'(cnt) - int'(i);
                if (tr_q)
                    lanes[i*BITS_AB +: BITS_AB] = mem[k[RW-1:0]][i*BITS_AB +: BITS_AB];
                else
                    lanes[i*BITS_AB +: BITS_AB] = mem[i][k*BITS_AB +: BITS_AB];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            en_out <= 1'b0;
            Aout   <= '0;
            for (int unsigned r = 0; r < DIM; r++)
                mem[r] <= '0;
        end else begin
            busy   <= (state == FEED);
            en_out <= (state == FEED);
            done   <= (state == FEED) && (cnt == LAST);
            Aout   <= (state == FEED) ? lanes : '0;
            case (state)
                IDLE: begin
                    // busy still shows the final feed cycle here; hold off until it drops.
                    if (!busy) begin
                        if (start) begin
                            state <= FEED;
                            cnt   <= '0;
                        end else if (WrEn && (int'(wr_row) < DIM)) begin
                            mem[wr_row] <= wr_data;
                        end
                    end
                end
                FEED: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tr_q <= 1'b0;
        else if ((state == IDLE) && !busy && start)
            tr_q <= transpose;
    end
`else
    assign tr_q = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder (DIM=4, BITS_AB=8).
module tb_systolic_feeder;

    localparam int DIM = 4;
    localparam int BW  = 8;
    localparam int NCYC = 3 * DIM - 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              WrEn = 1'b0;
    logic [1:0]        wr_row = '0;
    logic [DIM*BW-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              transpose = 1'b0;
    logic              busy, done, en_out;
    logic [DIM*BW-1:0] Aout;

    logic [BW-1:0] A [DIM][DIM];
    int errors = 0;
    int checks = 0;

    systolic_feeder #(.BITS_AB(BW), .DIM(DIM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .WrEn    (WrEn),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .start   (start),
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
        .transpose (transpose),
`endif
        .busy    (busy),
        .done    (done),
        .en_out  (en_out),
        .Aout    (Aout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] expect_lane(input int t, input int i, input bit tr);
        int k = t - i;
        if (k < 0 || k >= DIM) return '0;
        return tr ? A[k][i] : A[i][k];
    endfunction

    function automatic logic [DIM*BW-1:0] pack_row(input int r);
        logic [DIM*BW-1:0] v = '0;
        for (int j = 0; j < DIM; j++) v[j*BW +: BW] = A[r][j];
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) A[i][j] = '0;
    endtask

    task automatic write_row(input int r, input logic [DIM*BW-1:0] d);
        @(negedge clk);
        WrEn = 1'b1; wr_row = r[1:0]; wr_data = d;
        @(negedge clk);
        WrEn = 1'b0;
        for (int j = 0; j < DIM; j++) A[r][j] = d[j*BW +: BW];
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_en"},   64'(en_out), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_aout"}, 64'(Aout), 64'(0));
    endtask

    // wr_with_start: drive a row-0 write in the same cycle as start (must be dropped).
    task automatic run_feed(input string tag, input bit tr, input bit wr_with_start,
                            input int inject_t, input int reset_t);
        logic [DIM*BW-1:0] junk;
        @(negedge clk);
        start = 1'b1;
        transpose = tr;
        if (wr_with_start) begin
            WrEn = 1'b1; wr_row = 2'd0; wr_data = {DIM{8'h7F}};
        end
        @(negedge clk);
        start = 1'b0; WrEn = 1'b0; transpose = 1'b0;
        check($sformatf("%s_lat_busy", tag), 64'(busy), 64'(0));
        check($sformatf("%s_lat_en", tag), 64'(en_out), 64'(0));
        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            start = 1'b0; WrEn = 1'b0;
            check($sformatf("%s_t%0d_en", tag, t), 64'(en_out), 64'(1));
            check($sformatf("%s_t%0d_busy", tag, t), 64'(busy), 64'(1));
            check($sformatf("%s_t%0d_done", tag, t), 64'(done), 64'(t == NCYC - 1));
            for (int i = 0; i < DIM; i++)
                check($sformatf("%s_t%0d_lane%0d", tag, t, i),
                      64'(Aout[i*BW +: BW]), 64'(expect_lane(t, i, tr)));
            if (t == inject_t) begin
                junk = {$urandom, $urandom};
                start = 1'b1; WrEn = 1'b1; wr_row = 2'($urandom_range(0, DIM - 1)); wr_data = junk;
            end
            if (t == reset_t) begin
                rst_n = 1'b0;
                #1;
                check_idle($sformatf("%s_rst", tag));
                clear_model();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        start = 1'b0; WrEn = 1'b0;
        check_idle($sformatf("%s_end", tag));
    endtask

    initial begin
        clear_model();
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_feed("zero", 1'b0, 1'b0, -1, -1);

        // A[i][j] = 16*i + j + 1
        for (int i = 0; i < DIM; i++) begin
            logic [DIM*BW-1:0] d;
            for (int j = 0; j < DIM; j++) d[j*BW +: BW] = BW'(16 * i + j + 1);
            write_row(i, d);
        end
        run_feed("base", 1'b0, 1'b0, -1, -1);

        write_row(2, {DIM{8'h80}});
        run_feed("neg", 1'b0, 1'b0, -1, -1);

        run_feed("wrstart", 1'b0, 1'b1, -1, -1);
        write_row(0, {DIM{8'h7F}});
        run_feed("afterwr", 1'b0, 1'b0, -1, -1);

        run_feed("midinj", 1'b0, 1'b0, 4, -1);
        run_feed("midinj2", 1'b0, 1'b0, -1, -1);

`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
        for (int i = 0; i < DIM; i++) begin
            logic [DIM*BW-1:0] d;
            for (int j = 0; j < DIM; j++) d[j*BW +: BW] = BW'(16 * i + j + 1);
            write_row(i, d);
        end
        run_feed("trans", 1'b1, 1'b0, -1, -1);
        run_feed("untrans", 1'b0, 1'b0, -1, -1);
`endif

        for (int it = 0; it < 4; it++) begin
            bit tr = 1'b0;
            for (int w = 0; w < 6; w++)
                write_row($urandom_range(0, DIM - 1), {$urandom, $urandom});
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
            tr = 1'($urandom_range(0, 1));
`endif
            run_feed($sformatf("rnd%0d", it), tr, 1'b0, -1, -1);
        end

        run_feed("rstmid", 1'b0, 1'b0, -1, 5);
        run_feed("postrst", 1'b0, 1'b0, -1, -1);
        check("postrst_model_row0", 64'(pack_row(0)), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
